wb_uart: RTL and testbench

WB_UART -- requirements
Module: wb_uart

---
 rtl/wb_uart.sv | 216 +++++++++++++++++++++
 tb/tb_wb_uart.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart.sv
// Wishbone-attached 8N1 UART. It has a transmit FIFO, a single-byte receive holding register,
// and status/error flags that the host clears by writing 1s.
module wb_uart #(
  parameter int CLK_FREQ_HZ   = 100000000,
  parameter int BAUD          = 115200,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cycle,
  input  logic        wb_strobe,
  input  logic [31:0] wb_address,
  input  logic        wb_write_enable,
  input  logic [3:0]  wb_select,
  input  logic [31:0] wb_data_in,
  output logic [31:0] wb_data_out,
  output logic        wb_ack,
  output logic        tx,
  input  logic        rx
);

  localparam int DIVISOR = CLK_FREQ_HZ / BAUD;
  localparam int CW      = $clog2(DIVISOR);
  localparam int AW      = $clog2(TX_FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Bus decode; every side effect is qualified by accept so it happens exactly once per transfer.
  logic       accept, bus_wr, bus_rd, push_req, rx_read, status_wr;
  logic [1:0] offset;
  logic       unused_bits;
  assign accept    = wb_cycle & wb_strobe & ~wb_ack;
  assign offset    = wb_address[3:2];
  assign bus_wr    = accept & wb_write_enable & wb_select[0];
  assign bus_rd    = accept & ~wb_write_enable;
  assign push_req  = bus_wr & (offset == 2'd0);
  assign status_wr = bus_wr & (offset == 2'd2);
  assign rx_read   = bus_rd & (offset == 2'd1);
  assign unused_bits = ^{wb_address[31:4], wb_address[1:0], wb_select[3:1], wb_data_in[31:8]};

  // Transmit FIFO
  logic [7:0]    mem [TX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, tx_pop;
  assign full  = (count == (AW+1)'(TX_FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = push_req & (~full | tx_pop);

  // NOTE: the storage array is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wb_data_in[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, tx_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Transmit FSM
  uart_state_t   tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_tick;
  assign tx_tick = (tx_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge reset)
    if (reset) tx_state <= IDLE;
    else       tx_state <= tx_next;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      IDLE:  if (!empty) begin tx_next = START; tx_pop = 1'b1; end
      START: if (tx_tick) tx_next = DATA;
      DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = STOP;
      STOP:  if (tx_tick) begin
               if (!empty) begin tx_next = START; tx_pop = 1'b1; end
               else tx_next = IDLE;
             end
      default: tx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx <= (tx_state == START) ? 1'b0 : (tx_state == DATA) ? tx_shift[0] : 1'b1;
      if (tx_pop) begin
        tx_shift <= mem[rd_ptr];
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end else if (tx_state != IDLE) begin
        if (tx_tick) begin
          tx_cnt <= '0;
          if (tx_state == DATA) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 1'b1;
          end
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  // Receive path: two-flop synchronizer, then a falling-edge detector and a mid-bit sampler.
  uart_state_t   rx_state, rx_next;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_valid, rx_overrun, frame_err, deliver, frame_bad, rx_full_tick;
  assign rx_full_tick = (rx_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge reset)
    if (reset) rx_state <= IDLE;
    else       rx_state <= rx_next;

  always_comb begin
    rx_next   = rx_state;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    case (rx_state)
      IDLE:  if (rx_prev && !rx_sync) rx_next = START;
      START: if (rx_cnt == HALF_LAST) rx_next = rx_sync ? IDLE : DATA;
      DATA:  if (rx_full_tick && rx_bit == 3'd7) rx_next = STOP;
      STOP:  if (rx_full_tick) begin
               rx_next   = IDLE;
               deliver   = rx_sync;
               frame_bad = ~rx_sync;
             end
      default: rx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (rx_state == IDLE || rx_next != rx_state || (rx_state == DATA && rx_full_tick))
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == START) rx_bit <= '0;
      if (rx_state == DATA && rx_full_tick) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
      // Clears come first so a same-cycle set wins.
      if (status_wr && wb_data_in[3]) rx_overrun <= 1'b0;
      if (status_wr && wb_data_in[5]) frame_err  <= 1'b0;
      if (frame_bad) frame_err <= 1'b1;
      if (deliver) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid && !rx_read) rx_overrun <= 1'b1;
      end else if (rx_read) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Read mux and registered bus response
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (offset)
      2'd1:    rdata = {23'b0, rx_valid, rx_byte};
      2'd2:    rdata = {26'b0, frame_err, (tx_state != IDLE), rx_overrun, rx_valid, empty, full};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_ack      <= 1'b0;
      wb_data_out <= '0;
    end else begin
      wb_ack      <= accept;
      wb_data_out <= bus_rd ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_wb_uart.sv
// Directed self-checking bench for wb_uart at DIVISOR=10 (1 MHz clock, 100 kbaud).
module tb_wb_uart;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cycle = 1'b0, strobe = 1'b0, write_enable = 1'b0;
  logic [31:0] address = '0, data_in = '0;
  logic [3:0]  select = '0;
  logic [31:0] data_out;
  logic        ack, tx;
  logic        rx = 1'b1;
  int          checks = 0, errors = 0;

  wb_uart #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .TX_FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .wb_cycle(cycle), .wb_strobe(strobe), .wb_address(address),
    .wb_write_enable(write_enable), .wb_select(select), .wb_data_in(data_in),
    .wb_data_out(data_out), .wb_ack(ack), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  // One single-shot transfer; the acknowledge must be high on the cycle after acceptance.
  task automatic bus_xfer(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    @(negedge clk);
    cycle = 1'b1; strobe = 1'b1; address = addr; write_enable = we; select = sel; data_in = wdata;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL bus_ack addr=%h got %b want 1", addr, ack);
    end
    rdata = data_out;
    cycle = 1'b0; strobe = 1'b0; write_enable = 1'b0; select = '0;
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] unused_rd;
    bus_xfer(addr, 1'b1, 4'hF, wdata, unused_rd);
  endtask

  task automatic wb_read(input logic [31:0] addr, output logic [31:0] rdata);
    bus_xfer(addr, 1'b0, 4'hF, 32'h0, rdata);
  endtask

  // Receives one frame from tx; with detected=1 the caller is already one half-cycle into the start bit.
  task automatic tx_recv(input bit detected, output logic [7:0] b);
    int n = 0;
    b = '0;
    if (!detected) begin
      while (tx !== 1'b0 && n < 400) begin @(negedge clk); n++; end
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL tx_start_timeout got %b want 0", tx); end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL tx_start_bit got %b want 0", tx); end
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      b[i] = tx;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL tx_stop_bit got %b want 1", tx); end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop_bit;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || ack !== 1'b0 || data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got tx=%b ack=%b dout=%h want 1 0 0", tx, ack, data_out);
    end
    reset = 1'b0;
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL reset_status got %h want 00000002", r); end
    wb_read(32'h4, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_rxdata got %h want 00000000", r); end
  endtask

  task automatic test_bus;
    logic [31:0] r;
    int lows = 0;
    // Held request: ack alternates, data_out is zero whenever ack is low.
    @(negedge clk);
    cycle = 1'b1; strobe = 1'b1; address = 32'h8; write_enable = 1'b0; select = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ack !== ((i % 2) == 0) || data_out !== (((i % 2) == 0) ? 32'h2 : 32'h0)) begin
        errors++;
        $display("FAIL held_ack[%0d] got ack=%b dout=%h want ack=%b", i, ack, data_out, (i % 2) == 0);
      end
    end
    cycle = 1'b0; strobe = 1'b0;
    wb_read(32'hFFFF_F008, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL alias_status got %h want 00000002", r); end
    wb_read(32'hC, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL read_0xC got %h want 00000000", r); end
    wb_read(32'h0, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL read_txdata got %h want 00000000", r); end
    bus_xfer(32'h0, 1'b1, 4'b1110, 32'h12, r);
    wb_write(32'hC, 32'hFF);
    wb_write(32'h4, 32'hFF);
    repeat (20) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL masked_write_tx got %0d low cycles want 0", lows); end
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL ignored_writes_status got %h want 00000002", r); end
  endtask

  task automatic test_tx_single;
    logic [31:0] r;
    logic [7:0]  exp = 8'h55;
    wb_write(32'h0, 32'h55);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL tx_lat_n got %b want 1", tx); end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL tx_lat_n1 got %b want 1", tx); end
    @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL tx_lat_n2 got %b want 0", tx); end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      checks++;
      if (tx !== exp[i]) begin errors++; $display("FAIL tx_bit[%0d] got %b want %b", i, tx, exp[i]); end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL tx_stop got %b want 1", tx); end
    repeat (10) @(negedge clk);
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL tx_done_status got %h want 00000002", r); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    logic [7:0]  b;
    int lows = 0;
    fork
      begin
        wb_write(32'h0, 32'hFF);
        for (int i = 0; i <= 16; i++) wb_write(32'h0, i);
        wb_read(32'h8, r);
        checks++;
        if (r !== 32'h11) begin errors++; $display("FAIL b2b_full_status got %h want 00000011", r); end
      end
      begin
        tx_recv(1'b0, b);
        checks++;
        if (b !== 8'hFF) begin errors++; $display("FAIL b2b_frame0 got %h want ff", b); end
        for (int i = 0; i < 16; i++) begin
          repeat (4) @(negedge clk);
          checks++;
          if (tx !== 1'b1) begin errors++; $display("FAIL b2b_gap_end[%0d] got %b want 1", i, tx); end
          @(negedge clk);
          checks++;
          if (tx !== 1'b0) begin errors++; $display("FAIL b2b_contiguous[%0d] got %b want 0", i, tx); end
          tx_recv(1'b1, b);
          checks++;
          if (b !== 8'(i)) begin errors++; $display("FAIL b2b_frame[%0d] got %h want %h", i, b, 8'(i)); end
        end
      end
    join
    repeat (150) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL b2b_dropped_sent got %0d low cycles want 0", lows); end
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL b2b_end_status got %h want 00000002", r); end
  endtask

  task automatic test_rx_single;
    logic [31:0] r;
    send_rx(8'hA3, 1'b1);
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h6) begin errors++; $display("FAIL rx_status_valid got %h want 00000006", r); end
    wb_read(32'h4, r);
    checks++;
    if (r !== 32'h1A3) begin errors++; $display("FAIL rx_data got %h want 000001a3", r); end
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL rx_status_cleared got %h want 00000002", r); end
  endtask

  task automatic test_rx_overrun;
    logic [31:0] r;
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'hE) begin errors++; $display("FAIL overrun_status got %h want 0000000e", r); end
    wb_read(32'h4, r);
    checks++;
    if (r !== 32'h122) begin errors++; $display("FAIL overrun_data got %h want 00000122", r); end
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'hA) begin errors++; $display("FAIL overrun_after_read got %h want 0000000a", r); end
    wb_write(32'h8, 32'h8);
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL overrun_cleared got %h want 00000002", r); end
  endtask

  task automatic test_rx_glitch;
    logic [31:0] r;
    @(negedge clk) rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (120) @(negedge clk);
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL glitch_status got %h want 00000002", r); end
  endtask

  task automatic test_frame_error;
    logic [31:0] r;
    send_rx(8'h33, 1'b1);
    send_rx(8'h5A, 1'b0);
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h26) begin errors++; $display("FAIL frame_err_status got %h want 00000026", r); end
  endtask

  task automatic test_reset_mid_tx;
    logic [31:0] r;
    logic [7:0]  b;
    int n = 0, lows = 0;
    wb_write(32'h0, 32'h00);
    while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    repeat (55) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL mid_tx_bit4 got %b want 0", tx); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_async_tx got %b want 1", tx); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wb_read(32'h8, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL post_reset_status got %h want 00000002", r); end
    wb_read(32'h4, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL post_reset_rxdata got %h want 00000000", r); end
    repeat (120) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL frame_resumed got %0d low cycles want 0", lows); end
    fork
      wb_write(32'h0, 32'h55);
      tx_recv(1'b0, b);
    join
    checks++;
    if (b !== 8'h55) begin errors++; $display("FAIL post_reset_frame got %h want 55", b); end
  endtask

  initial begin
    test_reset();
    test_bus();
    test_tx_single();
    test_back_to_back();
    test_rx_single();
    test_rx_overrun();
    test_rx_glitch();
    test_frame_error();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
